// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and receiver state encoding.
// The transmitter uses CLKS_PER_BIT_DEF as well, so both ends of a link agree on bit timing.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned CNT_W            = 16;
  localparam int unsigned IDX_W            = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Both flops load RESET_VAL under reset so that the output settles immediately.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: finds the start edge, samples each bit at its centre and
// presents the byte with a one-cycle strobe, or pulses framing_error on a bad stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned      HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // Single-process FSM; busy is assigned alongside every state change so it
  // tracks state != IDLE without a combinational output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          // Re-check the line half a bit in; a high here means the edge was a glitch.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          // Leaving at mid-stop gives half a bit of slack to catch an immediate next start.
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        BREAK_WAIT: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: frames are pushed to a scoreboard as they are driven
// and popped by a strobe monitor; each scenario task also checks its own outcomes.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  // Start-bit drive (negedge) to strobe observation (negedge after the strobe edge):
  // one cycle to the first sampling edge, then 2 sync + HALF + 9*CPB.
  localparam int LATENCY = 1 + 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int fe_cnt      = 0;
  int busy_cnt    = 0;
  int start_cyc   = 0;

  logic [7:0] exp_q[$];
  int         vcyc_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: pops the scoreboard on every data_valid cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid && framing_error) begin
        vectors++;
        miscompares++;
        $display("FAIL strobe_exclusive: both strobes high at cycle %0d, required at most one", cyc);
      end
      if (data_valid) begin
        vectors++;
        valid_cnt++;
        vcyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: data_out=%02h at cycle %0d, no byte expected", data_out, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_out !== mon_exp) begin
            miscompares++;
            $display("FAIL rx_byte: got %02h expected %02h", data_out, mon_exp);
          end
        end
      end
      if (framing_error) fe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame from a negedge; expect_ok queues the byte for the monitor.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_ok);
    if (expect_ok) exp_q.push_back(b);
    start_cyc = cyc;
    rx = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle_cycles(CPB);
    end
    rx = stop;
    idle_cycles(CPB);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);
    vectors += 4;
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %02h expected 00", data_out); end
    if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    if (framing_error !== 1'b0) begin miscompares++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    idle_cycles(CPB);
  endtask

  task automatic test_basic();
    int v0, f0, lat;
    v0 = valid_cnt; f0 = fe_cnt;
    vcyc_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_cycles(CPB);
    vectors += 4;
    if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
    if (fe_cnt != f0) begin miscompares++; $display("FAIL basic_no_fe: got %0d expected 0", fe_cnt - f0); end
    if (data_out !== 8'hA5) begin miscompares++; $display("FAIL basic_hold: got %02h expected a5", data_out); end
    lat = (vcyc_q.size() > 0) ? vcyc_q[0] - start_cyc : -1;
    if (lat != LATENCY) begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", lat, LATENCY); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    busy_cnt = 0;
    rx = 1'b0;
    idle_cycles(4);
    rx = 1'b1;
    idle_cycles(3 * CPB);
    vectors += 4;
    if (valid_cnt != v0) begin miscompares++; $display("FAIL glitch_no_valid: got %0d expected 0", valid_cnt - v0); end
    if (fe_cnt != f0) begin miscompares++; $display("FAIL glitch_no_fe: got %0d expected 0", fe_cnt - f0); end
    if (busy_cnt == 0 || busy_cnt >= int'(HALF + 3))
      begin miscompares++; $display("FAIL glitch_busy_len: got %0d expected 1..%0d", busy_cnt, HALF + 2); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_framing();
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_cycles(2 * CPB);
    vectors += 4;
    if (fe_cnt - f0 != 1) begin miscompares++; $display("FAIL frame_fe_count: got %0d expected 1", fe_cnt - f0); end
    if (valid_cnt != v0) begin miscompares++; $display("FAIL frame_no_valid: got %0d expected 0", valid_cnt - v0); end
    if (data_out !== 8'hA5) begin miscompares++; $display("FAIL frame_data_kept: got %02h expected a5", data_out); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL frame_break_busy: got %b expected 1", busy); end
    rx = 1'b1;
    idle_cycles(CPB);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL frame_break_release: busy got %b expected 0", busy); end
    send_frame(8'h5A, 1'b1, 1'b1);
    idle_cycles(CPB);
    vectors += 2;
    if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL frame_recover_count: got %0d expected 1", valid_cnt - v0); end
    if (fe_cnt - f0 != 1) begin miscompares++; $display("FAIL frame_recover_fe: got %0d expected 1", fe_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    int gap;
    vcyc_q.delete();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle_cycles(CPB);
    gap = (vcyc_q.size() == 2) ? vcyc_q[1] - vcyc_q[0] : -1;
    vectors += 3;
    if (vcyc_q.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d expected 2", vcyc_q.size()); end
    if (gap != int'(10 * CPB)) begin miscompares++; $display("FAIL b2b_gap: got %0d expected %0d", gap, 10 * CPB); end
    if (data_out !== 8'hFF) begin miscompares++; $display("FAIL b2b_last: got %02h expected ff", data_out); end
  endtask

  // 0xF0 is high from bit 4 onward, so the tail of the aborted frame cannot look like a start.
  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] b;
    b = 8'hF0;
    v0 = valid_cnt; f0 = fe_cnt;
    rx = 1'b0;
    idle_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle_cycles(CPB);
    end
    rx = b[4];
    idle_cycles(HALF);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    vectors += 4;
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL rstmid_data_out: got %02h expected 00", data_out); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b expected 0", data_valid); end
    if (framing_error !== 1'b0) begin miscompares++; $display("FAIL rstmid_fe: got %b expected 0", framing_error); end
    idle_cycles(HALF - 1);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      idle_cycles(CPB);
    end
    rx = 1'b1;
    idle_cycles(3 * CPB);
    vectors += 2;
    if (valid_cnt != v0 || fe_cnt != f0)
      begin miscompares++; $display("FAIL rstmid_no_strobe: valid %0d fe %0d expected 0 0", valid_cnt - v0, fe_cnt - f0); end
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL rstmid_discard: got %02h expected 00", data_out); end
    send_frame(8'h81, 1'b1, 1'b1);
    idle_cycles(CPB);
    vectors++;
    if (data_out !== 8'h81) begin miscompares++; $display("FAIL rstmid_next: got %02h expected 81", data_out); end
  endtask

  // Transmitter-style stream: matched bit timing, one idle bit between frames.
  task automatic test_loopback();
    int v0, f0;
    logic [7:0] tx_bytes[4];
    tx_bytes = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    v0 = valid_cnt; f0 = fe_cnt;
    foreach (tx_bytes[i]) begin
      send_frame(tx_bytes[i], 1'b1, 1'b1);
      idle_cycles(CPB);
    end
    vectors += 2;
    if (valid_cnt - v0 != 4) begin miscompares++; $display("FAIL loop_count: got %0d expected 4", valid_cnt - v0); end
    if (fe_cnt != f0) begin miscompares++; $display("FAIL loop_fe: got %0d expected 0", fe_cnt - f0); end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d bytes never received, expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the downstream stage of the team's UART transmitter. It consumes the Tx line directly or through board loopback.
- Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1). Line idles high.
- Recovers each byte by counting clocks to the bit centre. Presents the byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period. Must be >= 4 and even. HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly framed byte; holds until the next good frame.
- data_valid  output  1  one-cycle pulse; data_out is valid and newly updated this cycle.
- framing_error  output  1  one-cycle pulse; stop bit sampled 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Synchroniser:
  - rx passes through two flops to give rx_s. All decisions use rx_s only.
  - Both synchroniser flops reset to 1.
- Reset values: data_out=0x00, data_valid=0, framing_error=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame: on the next edge everything returns to the reset values. The partial byte is discarded and no strobe is issued.
- State machine: IDLE, START, DATA, STOP, BREAK_WAIT. A 16-bit clock counter cnt and a 3-bit bit index idx drive the transitions below.
- IDLE: when rx_s==0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1: if rx_s==0, go to DATA with cnt=0, idx=0. Otherwise this was a glitch; return to IDLE with no output.
- DATA:
  - At cnt==CLKS_PER_BIT-1: shift rx_s into the shift register MSB; the register shifts right, so the first bit ends at bit 0. Then set cnt=0.
  - If idx==7, go to STOP; otherwise idx increments.
- STOP, at cnt==CLKS_PER_BIT-1:
  - rx_s==1: data_out <= shift register, data_valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0: framing_error=1 for one cycle, data_out unchanged, go to BREAK_WAIT.
- BREAK_WAIT: stays until rx_s==1, then goes to IDLE. This stops a held-low break line from being read as repeated 0x00 frames.
- Sampling points: every sample lands at bit centre relative to the detected falling edge.
- Latency: data_valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT cycles after the rx falling edge of the start bit, within ±1 cycle of edge-detect uncertainty.
- Back-to-back frames:
  - The machine returns to IDLE at the mid-stop sample, half a bit before the stop bit ends.
  - A start edge immediately after the stop bit must be caught, with no dead time beyond one cycle.
- Strobe exclusivity: data_valid and framing_error are never high in the same cycle.
- No FIFO: consumers must capture data_out on data_valid. A new frame overwrites data_out.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, BREAK_WAIT=4)
  - DATA_BITS=8
  - default CLKS_PER_BIT; this must also be used by the transmitter so the two ends match.
- Sub-module: sync_2ff, a generic two-flop synchroniser with a reset value parameter. It is reusable by other protocol blocks.
- All remaining logic is a single FSM in uart_rx.

Test Plan:
- 0xA5 frame at CLKS_PER_BIT=16 (bits 1,0,1,0,0,1,0,1 LSB first):
  - data_out=0xA5 with data_valid high for exactly one cycle, about 2+8+144 cycles after the start edge.
  - framing_error stays 0.
- 4-cycle low glitch on an idle line: returns to IDLE; no data_valid, no framing_error; busy high for fewer than HALF_BIT+3 cycles.
- Frame 0x3C with stop bit forced to 0:
  - framing_error pulses once; data_out keeps its prior value (0xA5).
  - busy stays high until the line returns high, then a following 0x5A frame is received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap: two data_valid pulses, 160 cycles apart, with data_out 0x00 then 0xFF.
- reset asserted for 1 cycle during data bit 4 of a frame: outputs return to reset values, no strobe. The next clean frame 0x81 is received correctly.
- Loopback from the team's UART transmitter sending 0x00, 0x55, 0xAA, 0xFF at matched CLKS_PER_BIT: all four bytes received in order with zero framing errors.
